// File: rtl/keypad_matrix_scan.sv
// rtl/keypad_matrix_scan.sv - 4x4 keypad row scanner resolving each frame to one key code
// Rows are driven low in turn; synchronized columns are sampled once per row at the end of its drive window.
module keypad_matrix_scan #(
   parameter int CLK_KHZ = 25175,
   parameter int ROW_US  = 40
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row_out,
   input  logic [3:0] col_in,
   output logic [4:0] key_code,
   output logic       multi,
   output logic       frame_done
);

   localparam int ROW_CYC = CLK_KHZ * ROW_US / 1000;
   localparam int CNT_W   = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_CYC - 1);

   if (ROW_CYC < 4) begin : g_row_cyc_check
      $error("keypad_matrix_scan: ROW_CYC must be at least 4");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_UPDATE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       col_s1_q, col_s_q;
   logic [4:0]       first_code_q, first_code_d;
   logic [1:0]       hit_cnt_q, hit_cnt_d;
   logic [4:0]       key_code_q, key_code_d;
   logic             multi_q, multi_d;
   logic             frame_done_q, frame_done_d;
   logic [4:0]       code;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      cnt_d        = cnt_q;
      first_code_d = first_code_q;
      hit_cnt_d    = hit_cnt_q;
      key_code_d   = key_code_q;
      multi_d      = multi_q;
      frame_done_d = 1'b0;
      row_out      = 4'b1111;
      code         = 5'd0;

      case (state_q)
         S_IDLE: begin
            state_d = S_DRIVE;
            row_d   = 2'd0;
            cnt_d   = '0;
         end
         S_DRIVE: begin
            row_out = ~(4'b0001 << row_q);
            if (cnt_q == CNT_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            row_out = ~(4'b0001 << row_q);
            // Rows and columns are visited in ascending order, so the first hit is the lowest code.
            for (int c = 0; c < 4; c++) begin
               if (!col_s_q[c]) begin
                  code = 5'({row_q, 2'(c)}) + 5'd1;
                  if (hit_cnt_d == 2'd0) begin
                     first_code_d = code;
                  end
                  if (hit_cnt_d != 2'd2) begin
                     hit_cnt_d = hit_cnt_d + 2'd1;
                  end
               end
            end
            if (row_q != 2'd3) begin
               row_d   = row_q + 2'd1;
               cnt_d   = '0;
               state_d = S_DRIVE;
            end else begin
               // Results are registered on entry to UPDATE so they are valid alongside frame_done.
               key_code_d   = (hit_cnt_d == 2'd1) ? first_code_d : 5'd0;
               multi_d      = (hit_cnt_d == 2'd2);
               frame_done_d = 1'b1;
               state_d      = S_UPDATE;
            end
         end
         S_UPDATE: begin
            first_code_d = 5'd0;
            hit_cnt_d    = 2'd0;
            row_d        = 2'd0;
            cnt_d        = '0;
            state_d      = S_DRIVE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         row_q        <= 2'd0;
         cnt_q        <= '0;
         col_s1_q     <= 4'b1111;
         col_s_q      <= 4'b1111;
         first_code_q <= 5'd0;
         hit_cnt_q    <= 2'd0;
         key_code_q   <= 5'd0;
         multi_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         cnt_q        <= cnt_d;
         col_s1_q     <= col_in;
         col_s_q      <= col_s1_q;
         first_code_q <= first_code_d;
         hit_cnt_q    <= hit_cnt_d;
         key_code_q   <= key_code_d;
         multi_q      <= multi_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign key_code   = key_code_q;
   assign multi      = multi_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb/tb_keypad_matrix_scan.sv - directed bench for keypad_matrix_scan with a passive keypad model
module tb_keypad_matrix_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_out;
    logic [3:0] col_in;
    logic [4:0] key_code;
    logic       multi;
    logic       frame_done;

    logic [15:0] keys;
    logic [3:0]  glitch;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    keypad_matrix_scan #(.CLK_KHZ(100), .ROW_US(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_out    (row_out),
        .col_in     (col_in),
        .key_code   (key_code),
        .multi      (multi),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            logic pressed;
            pressed = 1'b0;
            for (int r = 0; r < 4; r++) begin
                if (!row_out[r] && keys[r*4+c]) pressed = 1'b1;
            end
            col_in[c] = ~(pressed | glitch[c]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 50);
        check("frame_done_timeout", 32'(n < 50), 32'd1);
    endtask

    initial begin
        int n;
        int m;
        logic [3:0] exp_row;

        rst    = 1'b1;
        keys   = 16'h0000;
        glitch = 4'b0000;
        step(3);
        check("rst_row_out", 32'(row_out), 32'(4'b1111));
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        rst = 1'b0;
        check("idle_row_out", 32'(row_out), 32'(4'b1111));
        for (int k = 1; k <= 63; k++) begin
            step(1);
            m = k % 21;
            exp_row = (m == 0) ? 4'b1111 : ~(4'b0001 << ((m - 1) / 5));
            check("scan_row_out", 32'(row_out), 32'(exp_row));
            check("scan_frame_done", 32'(frame_done), 32'(m == 0));
            check("scan_key_code", 32'(key_code), 32'd0);
            check("scan_multi", 32'(multi), 32'd0);
        end

        rst  = 1'b1;
        keys = 16'h0200;
        step(2);
        rst = 1'b0;
        wait_fd(n);
        check("key10_first_fd_cycle", 32'(n), 32'd21);
        check("key10_code", 32'(key_code), 32'd10);
        check("key10_multi", 32'(multi), 32'd0);
        step(7);
        check("key10_hold_midframe", 32'(key_code), 32'd10);
        wait_fd(n);
        check("key10_hold_code", 32'(key_code), 32'd10);
        keys = 16'h0000;
        wait_fd(n);
        wait_fd(n);
        check("key10_release", 32'(key_code), 32'd0);

        keys = 16'h8001;
        wait_fd(n);
        check("two_keys_code", 32'(key_code), 32'd0);
        check("two_keys_multi", 32'(multi), 32'd1);
        keys = 16'h0001;
        wait_fd(n);
        check("key1_code", 32'(key_code), 32'd1);
        check("key1_multi", 32'(multi), 32'd0);

        keys = 16'h0050;
        wait_fd(n);
        check("same_row_code", 32'(key_code), 32'd0);
        check("same_row_multi", 32'(multi), 32'd1);

        keys = 16'h8000;
        wait_fd(n);
        check("key16_code", 32'(key_code), 32'd16);
        check("key16_multi", 32'(multi), 32'd0);
        step(12);
        check("mid_row2_row_out", 32'(row_out), 32'(4'b1011));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_row_out", 32'(row_out), 32'(4'b1111));
        check("midrst_key_code", 32'(key_code), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_multi", 32'(multi), 32'd0);
        step(1);
        check("restart_row0", 32'(row_out), 32'(4'b1110));
        step(20);
        check("restart_frame_done", 32'(frame_done), 32'd1);
        check("restart_key16", 32'(key_code), 32'd16);

        keys = 16'h0000;
        wait_fd(n);
        wait_fd(n);
        check("pre_glitch_code", 32'(key_code), 32'd0);
        step(2);
        glitch = 4'b0001;
        step(1);
        glitch = 4'b0000;
        wait_fd(n);
        check("glitch_code", 32'(key_code), 32'd0);
        check("glitch_multi", 32'(multi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
